// File: rtl/mvm_seq_ctrl.sv
// Fetch / MAC / write-back sequencer for an N x N matrix-vector product Y = H*S.
// Optional feature macro SEQ_ABORT_EN adds the abort input and the aborted pulse output.
module mvm_seq_ctrl #(
    parameter int N       = 4,
    parameter int AW      = 4,
    parameter int OW      = 3,
    parameter int ROM_LAT = 1,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
`ifdef SEQ_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          busy,
    output logic          rd_en,
    output logic [AW-1:0] addr_h,
    output logic [AW-1:0] addr_s,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          out_we,
    output logic [OW-1:0] addr_out,
    output logic          done
);

    localparam int            D      = ROM_LAT + MAC_LAT;
    localparam logic [AW-1:0] J_LAST = AW'(N - 1);
    localparam logic [OW-1:0] I_LAST = OW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [OW-1:0]         i_q, i_d;
    logic [AW-1:0]         j_q, j_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         addr_h_q, addr_h_d;
    logic [AW-1:0]         addr_s_q, addr_s_d;
    logic [OW-1:0]         addr_out_q, addr_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Tag delay lines: bit 0 belongs to the fetch presented this cycle,
    // bit k to the fetch presented k cycles ago.
    logic [D-1:0]          vld_q, vld_d;
    logic [D:0]            lst_q, lst_d;
    logic [ROM_LAT:0]      fst_q, fst_d;
    logic [D-1:0][OW-1:0]  row_q, row_d;

    logic                  issue;
    logic                  fetch_last;
    logic                  pending;
    logic                  abort_now;

`ifdef SEQ_ABORT_EN
    logic                  aborted_q, aborted_d;

    assign abort_now = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign aborted_d = abort_now;
    assign aborted   = aborted_q;
`else
    assign abort_now = 1'b0;
`endif

    assign fetch_last = (i_q == I_LAST) && (j_q == J_LAST);
    assign issue      = !abort_now &&
                        (((state_q == S_IDLE) && start) || ((state_q == S_RUN) && !hold));
    // Anything younger than the out_we tap still has an output left to produce.
    assign pending    = |vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = fetch_last ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (!hold && fetch_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pending) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_now) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        idx_d      = idx_q;
        addr_h_d   = addr_h_q;
        addr_s_d   = addr_s_q;
        vld_d      = {vld_q[D-2:0], issue};
        lst_d      = {lst_q[D-1:0], issue && (j_q == J_LAST)};
        fst_d      = {fst_q[ROM_LAT-1:0], issue && (j_q == '0)};
        row_d      = {row_q[D-2:0], i_q};
        addr_out_d = lst_q[D-1] ? row_q[D-1] : addr_out_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);

        if (issue) begin
            addr_h_d = idx_q;
            addr_s_d = j_q;
            if (fetch_last) begin
                i_d   = '0;
                j_d   = '0;
                idx_d = '0;
            end else begin
                idx_d = idx_q + AW'(1);
                if (j_q == J_LAST) begin
                    j_d = '0;
                    i_d = i_q + OW'(1);
                end else begin
                    j_d = j_q + AW'(1);
                end
            end
        end

        // An abort drops every in-flight tag so no late strobes escape.
        if (abort_now) begin
            vld_d = '0;
            lst_d = '0;
            fst_d = '0;
            i_d   = '0;
            j_d   = '0;
            idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q        <= '0;
            j_q        <= '0;
            idx_q      <= '0;
            addr_h_q   <= '0;
            addr_s_q   <= '0;
            addr_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_q      <= '0;
            lst_q      <= '0;
            fst_q      <= '0;
            row_q      <= '0;
`ifdef SEQ_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            i_q        <= i_d;
            j_q        <= j_d;
            idx_q      <= idx_d;
            addr_h_q   <= addr_h_d;
            addr_s_q   <= addr_s_d;
            addr_out_q <= addr_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld_q      <= vld_d;
            lst_q      <= lst_d;
            fst_q      <= fst_d;
            row_q      <= row_d;
`ifdef SEQ_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign rd_en    = vld_q[0];
    assign addr_h   = addr_h_q;
    assign addr_s   = addr_s_q;
    assign mac_en   = vld_q[ROM_LAT];
    assign mac_clr  = fst_q[ROM_LAT];
    assign out_we   = lst_q[D];
    assign addr_out = addr_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Directed bench for mvm_seq_ctrl: cycle table for the nominal pass plus hold, reset,
// small-matrix and (with SEQ_ABORT_EN) abort sequences.
`timescale 1ns/1ps
module tb_mvm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       hold;

    logic       busy, rd_en, mac_clr, mac_en, out_we, done;
    logic [3:0] addr_h, addr_s;
    logic [2:0] addr_out;

    logic       busy_2, rd_en_2, mac_clr_2, mac_en_2, out_we_2, done_2;
    logic [1:0] addr_h_2, addr_s_2;
    logic [0:0] addr_out_2;

`ifdef SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
    logic       abort_2;
    logic       aborted_2;
`endif

    int checks = 0;
    int errors = 0;

    mvm_seq_ctrl #(.N(4), .AW(4), .OW(3), .ROM_LAT(1), .MAC_LAT(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hold     (hold),
`ifdef SEQ_ABORT_EN
        .abort    (abort),
        .aborted  (aborted),
`endif
        .busy     (busy),
        .rd_en    (rd_en),
        .addr_h   (addr_h),
        .addr_s   (addr_s),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .out_we   (out_we),
        .addr_out (addr_out),
        .done     (done)
    );

    mvm_seq_ctrl #(.N(2), .AW(2), .OW(1), .ROM_LAT(2), .MAC_LAT(1)) u_dut_2 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hold     (hold),
`ifdef SEQ_ABORT_EN
        .abort    (abort_2),
        .aborted  (aborted_2),
`endif
        .busy     (busy_2),
        .rd_en    (rd_en_2),
        .addr_h   (addr_h_2),
        .addr_s   (addr_s_2),
        .mac_clr  (mac_clr_2),
        .mac_en   (mac_en_2),
        .out_we   (out_we_2),
        .addr_out (addr_out_2),
        .done     (done_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic hold;
        logic rd_en;
        int   addr_h;
        int   addr_s;
        logic mac_en;
        logic mac_clr;
        logic out_we;
        int   addr_out;
        logic busy;
        logic done;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    // Per-cycle input schedule and recorded outputs for the hand-written sequences.
    logic [63:0] s_start, s_hold, s_rst, s_abort;
    logic [63:0] r_rd, r_me, r_mc, r_we, r_bz, r_dn, r_ab;
    logic [63:0] r_rd2, r_mc2, r_we2, r_bz2, r_dn2;
    int          r_ah[64], r_as[64], r_ao[64];
    int          r_ah2[64], r_ao2[64];

    function automatic vec_t mk_vec(input logic s, input logic h, input logic rd, input int ah,
                                    input int sa, input logic me, input logic mc, input logic we,
                                    input int ao, input logic bz, input logic dn);
        vec_t v;
        v.start = s;   v.hold = h;    v.rd_en = rd;   v.addr_h = ah;  v.addr_s = sa;
        v.mac_en = me; v.mac_clr = mc; v.out_we = we; v.addr_out = ao;
        v.busy = bz;   v.done = dn;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic h, input logic r);
        start = s;
        hold  = h;
        rst   = r;
    endtask

    task automatic reset_dut();
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_vec(input int c);
        checkOutput($sformatf("c%0d.rd_en", c),    int'(rd_en),    int'(vecs[c].rd_en));
        checkOutput($sformatf("c%0d.addr_h", c),   int'(addr_h),   vecs[c].addr_h);
        checkOutput($sformatf("c%0d.addr_s", c),   int'(addr_s),   vecs[c].addr_s);
        checkOutput($sformatf("c%0d.mac_en", c),   int'(mac_en),   int'(vecs[c].mac_en));
        checkOutput($sformatf("c%0d.mac_clr", c),  int'(mac_clr),  int'(vecs[c].mac_clr));
        checkOutput($sformatf("c%0d.out_we", c),   int'(out_we),   int'(vecs[c].out_we));
        checkOutput($sformatf("c%0d.addr_out", c), int'(addr_out), vecs[c].addr_out);
        checkOutput($sformatf("c%0d.busy", c),     int'(busy),     int'(vecs[c].busy));
        checkOutput($sformatf("c%0d.done", c),     int'(done),     int'(vecs[c].done));
    endtask

    // Row c holds the inputs driven in cycle c (sampled at edge c) and the outputs seen in cycle c.
    task automatic run_table();
        for (int c = 0; c < NV; c++) begin
            check_vec(c);
            applyStimulus(vecs[c].start, vecs[c].hold, 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_sched();
        s_start = '0;
        s_hold  = '0;
        s_rst   = '0;
        s_abort = '0;
    endtask

    task automatic run_seq(input int ncyc);
        r_rd = '0; r_me = '0; r_mc = '0; r_we = '0; r_bz = '0; r_dn = '0; r_ab = '0;
        r_rd2 = '0; r_mc2 = '0; r_we2 = '0; r_bz2 = '0; r_dn2 = '0;
        for (int c = 0; c < ncyc; c++) begin
            r_rd[c]  = rd_en;   r_me[c]  = mac_en;   r_mc[c] = mac_clr;
            r_we[c]  = out_we;  r_bz[c]  = busy;     r_dn[c] = done;
            r_ah[c]  = int'(addr_h);   r_as[c]  = int'(addr_s);   r_ao[c] = int'(addr_out);
            r_rd2[c] = rd_en_2; r_mc2[c] = mac_clr_2; r_we2[c] = out_we_2;
            r_bz2[c] = busy_2;  r_dn2[c] = done_2;
            r_ah2[c] = int'(addr_h_2); r_ao2[c] = int'(addr_out_2);
`ifdef SEQ_ABORT_EN
            r_ab[c]  = aborted;
            abort    = s_abort[c];
`endif
            applyStimulus(s_start[c], s_hold[c], s_rst[c]);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef SEQ_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        // Nominal pass; the start in cycle 8 arrives while busy and must be ignored.
        vecs[0]  = mk_vec(1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk_vec(0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk_vec(0, 0, 1,  1, 1, 1, 1, 0, 0, 1, 0);
        vecs[3]  = mk_vec(0, 0, 1,  2, 2, 1, 0, 0, 0, 1, 0);
        vecs[4]  = mk_vec(0, 0, 1,  3, 3, 1, 0, 0, 0, 1, 0);
        vecs[5]  = mk_vec(0, 0, 1,  4, 0, 1, 0, 0, 0, 1, 0);
        vecs[6]  = mk_vec(0, 0, 1,  5, 1, 1, 1, 0, 0, 1, 0);
        vecs[7]  = mk_vec(0, 0, 1,  6, 2, 1, 0, 1, 0, 1, 0);
        vecs[8]  = mk_vec(1, 0, 1,  7, 3, 1, 0, 0, 0, 1, 0);
        vecs[9]  = mk_vec(0, 0, 1,  8, 0, 1, 0, 0, 0, 1, 0);
        vecs[10] = mk_vec(0, 0, 1,  9, 1, 1, 1, 0, 0, 1, 0);
        vecs[11] = mk_vec(0, 0, 1, 10, 2, 1, 0, 1, 1, 1, 0);
        vecs[12] = mk_vec(0, 0, 1, 11, 3, 1, 0, 0, 1, 1, 0);
        vecs[13] = mk_vec(0, 0, 1, 12, 0, 1, 0, 0, 1, 1, 0);
        vecs[14] = mk_vec(0, 0, 1, 13, 1, 1, 1, 0, 1, 1, 0);
        vecs[15] = mk_vec(0, 0, 1, 14, 2, 1, 0, 1, 2, 1, 0);
        vecs[16] = mk_vec(0, 0, 1, 15, 3, 1, 0, 0, 2, 1, 0);
        vecs[17] = mk_vec(0, 1, 0, 15, 3, 1, 0, 0, 2, 1, 0);
        vecs[18] = mk_vec(0, 1, 0, 15, 3, 0, 0, 0, 2, 1, 0);
        vecs[19] = mk_vec(0, 0, 0, 15, 3, 0, 0, 1, 3, 1, 0);
        vecs[20] = mk_vec(0, 0, 0, 15, 3, 0, 0, 0, 3, 1, 1);
        vecs[21] = mk_vec(0, 0, 0, 15, 3, 0, 0, 0, 3, 0, 0);
        vecs[22] = mk_vec(0, 0, 0, 15, 3, 0, 0, 0, 3, 0, 0);
        vecs[23] = mk_vec(0, 0, 0, 15, 3, 0, 0, 0, 3, 0, 0);

        applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef SEQ_ABORT_EN
        abort   = 1'b0;
        abort_2 = 1'b0;
`endif
        clear_sched();

        $display("[TB] nominal pass");
        reset_dut();
        run_table();

        $display("[TB] hold high in cycles 3..5");
        reset_dut();
        clear_sched();
        s_start[0] = 1'b1;
        s_hold[5:3] = 3'b111;
        run_seq(32);
        checkOutput("hold.rd_en_map",  int'(r_rd[31:0]), 32'h000F_FF8E);
        checkOutput("hold.mac_en_map", int'(r_me[31:0]), 32'h001F_FF1C);
        checkOutput("hold.mac_en_cnt", $countones(r_me), 16);
        checkOutput("hold.out_we_map", int'(r_we[31:0]), 32'h0044_4400);
        checkOutput("hold.done_map",   int'(r_dn[31:0]), 32'h0080_0000);
        checkOutput("hold.busy_map",   int'(r_bz[31:0]), 32'h00FF_FFFE);
        for (int c = 4; c <= 6; c++) begin
            checkOutput($sformatf("hold.addr_h_c%0d", c), r_ah[c], 2);
        end
        checkOutput("hold.addr_h_c7", r_ah[7], 3);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("hold.addr_out_row%0d", k), r_ao[10 + 4 * k], k);
        end

        $display("[TB] reset asserted in cycle 9");
        reset_dut();
        clear_sched();
        s_start[0] = 1'b1;
        s_rst[9]   = 1'b1;
        run_seq(32);
        checkOutput("rst.rd_en_map",  int'(r_rd[31:0]), 32'h0000_03FE);
        checkOutput("rst.mac_en_map", int'(r_me[31:0]), 32'h0000_03FC);
        checkOutput("rst.out_we_map", int'(r_we[31:0]), 32'h0000_0080);
        checkOutput("rst.done_map",   int'(r_dn[31:0]), 0);
        checkOutput("rst.busy_map",   int'(r_bz[31:0]), 32'h0000_03FE);
        checkOutput("rst.addr_h_c10", r_ah[10], 0);
        checkOutput("rst.addr_s_c10", r_as[10], 0);
        checkOutput("rst.mac_clr_c10", int'(r_mc[10]), 0);
        $display("[TB] fresh start after mid-pass reset");
        run_table();

        $display("[TB] N=2 ROM_LAT=2 MAC_LAT=1");
        reset_dut();
        clear_sched();
        s_start[0] = 1'b1;
        run_seq(16);
        checkOutput("n2.rd_en_map",   int'(r_rd2[15:0]), 16'h001E);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("n2.addr_h_c%0d", c), r_ah2[c], c - 1);
        end
        checkOutput("n2.mac_clr_map", int'(r_mc2[15:0]), 16'h0028);
        checkOutput("n2.out_we_map",  int'(r_we2[15:0]), 16'h00A0);
        checkOutput("n2.addr_out_c5", r_ao2[5], 0);
        checkOutput("n2.addr_out_c7", r_ao2[7], 1);
        checkOutput("n2.done_map",    int'(r_dn2[15:0]), 16'h0100);
        checkOutput("n2.busy_map",    int'(r_bz2[15:0]), 16'h01FE);

`ifdef SEQ_ABORT_EN
        $display("[TB] abort in cycle 10");
        reset_dut();
        clear_sched();
        s_start[0] = 1'b1;
        s_abort[10] = 1'b1;
        run_seq(32);
        checkOutput("abort.aborted_map", int'(r_ab[31:0]), 32'h0000_0800);
        checkOutput("abort.rd_en_map",   int'(r_rd[31:0]), 32'h0000_07FE);
        checkOutput("abort.mac_en_map",  int'(r_me[31:0]), 32'h0000_07FC);
        checkOutput("abort.out_we_map",  int'(r_we[31:0]), 32'h0000_0080);
        checkOutput("abort.done_map",    int'(r_dn[31:0]), 0);
        checkOutput("abort.busy_map",    int'(r_bz[31:0]), 32'h0000_07FE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
